// File: rtl/aes_enc_core_param.sv
// Iterative AES encryptor: 128/192/256-bit keys, 1/2/4 state columns per cycle,
// with the key schedule expanded on the fly from a sliding window of Nk words.
module aes_enc_core_param #(
    parameter int KEY_BITS = 128,
    parameter int COLS     = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    localparam int NK     = KEY_BITS / 32;
    localparam int NR     = NK + 6;
    localparam int S      = 4 / COLS;
    localparam int LAST_W = 4 * NR + 3;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
    fsm_t fsm_q, fsm_d;

    logic [3:0]   round_q;
    logic [1:0]   step_q;
    logic [127:0] state_q, nxt_q, nxt_full;
    logic [31:0]  kwin_q [NK];
    logic [31:0]  ext [NK+4];
    logic [31:0]  rk [4];
    logic [31:0]  st_col [4];
    logic [31:0]  nx_col [4];
    logic [7:0]   sb [4];
    logic [31:0]  mixed, tmp;
    logic [1:0]   col, src;
    int           wi;
    logic         accept, last_step, last_round;
    logic         unused_key;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, inv;
        p   = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int idx);
        case (idx)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    assign last_step  = (step_q == 2'(S - 1));
    assign last_round = (round_q == 4'(NR));
    assign accept     = in_valid & in_ready;
    assign out_valid  = (fsm_q == DONE);
    assign busy       = (fsm_q == ROUND);
    assign data_out   = (fsm_q == DONE) ? state_q : 128'h0;
    assign unused_key = ^key[127:0];

    always_comb begin
        fsm_d    = fsm_q;
        in_ready = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) fsm_d = ROUND;
            end
            ROUND: begin
                if (last_step && last_round) fsm_d = DONE;
            end
            DONE: begin
                in_ready = !reset & out_ready;
                if (out_ready) fsm_d = in_valid ? ROUND : IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Window holds w[4(r-1) ..]; words 4..7 of the extended array are round r's key.
    always_comb begin
        wi  = 0;
        tmp = '0;
        for (int j = 0; j < NK; j++) ext[j] = kwin_q[j];
        for (int j = NK; j < NK + 4; j++) ext[j] = '0;
        for (int k = 0; k < 4; k++) begin
            wi  = 4 * (int'(round_q) - 1) + NK + k;
            tmp = ext[NK+k-1];
            if (wi % NK == 0)
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(wi / NK), 24'h0};
            else if (NK == 8 && wi % 8 == 4)
                tmp = sub_word(tmp);
            if (wi <= LAST_W) ext[NK+k] = ext[k] ^ tmp;
        end
        for (int c = 0; c < 4; c++) rk[c] = ext[4+c];
    end

    // Round datapath: COLS columns per cycle, ShiftRows reads the whole current state.
    always_comb begin
        col   = '0;
        src   = '0;
        mixed = '0;
        for (int r = 0; r < 4; r++) sb[r] = '0;
        for (int c = 0; c < 4; c++) begin
            st_col[c] = state_q[127-32*c -: 32];
            nx_col[c] = nxt_q[127-32*c -: 32];
        end
        for (int k = 0; k < COLS; k++) begin
            col = 2'(int'(step_q) * COLS + k);
            for (int r = 0; r < 4; r++) begin
                src   = col + 2'(r);
                sb[r] = sbox(st_col[src][31-8*r -: 8]);
            end
            mixed = last_round ? {sb[0], sb[1], sb[2], sb[3]}
                               : mix_col({sb[0], sb[1], sb[2], sb[3]});
            nx_col[col] = mixed ^ rk[col];
        end
        nxt_full = {nx_col[0], nx_col[1], nx_col[2], nx_col[3]};
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            state_q <= data_in ^ key[255:128];
            for (int j = 0; j < NK; j++) kwin_q[j] <= key[255-32*j -: 32];
        end else if (fsm_q == ROUND) begin
            nxt_q <= nxt_full;
            if (last_step) begin
                state_q <= nxt_full;
                for (int j = 0; j < NK; j++) kwin_q[j] <= ext[4+j];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            step_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                round_q <= 4'd1;
                step_q  <= '0;
            end else if (fsm_q == ROUND) begin
                if (last_step) begin
                    step_q  <= '0;
                    round_q <= round_q + 4'd1;
                end else begin
                    step_q <= step_q + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_enc_core_param.sv
// Directed bench: a 128/COLS=4 core for handshake, back-pressure and reset scenarios,
// plus a grid of key-length/width variants run on the FIPS-197 Appendix C vectors.
module tb_aes_enc_core_param;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    localparam int NG = 8;
    localparam int G_KB   [NG] = '{128, 128, 192, 192, 192, 256, 256, 256};
    localparam int G_COLS [NG] = '{1, 2, 1, 2, 4, 1, 2, 4};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic         m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_busy;
    logic [127:0] m_data_in, m_data_out;
    logic [255:0] m_key;

    logic         g_in_valid, g_out_ready;
    logic [127:0] g_data_in;
    logic [255:0] g_key;
    logic         g_in_ready [NG];
    logic         g_out_valid [NG];
    logic         g_busy [NG];
    logic [127:0] g_data_out [NG];

    int checks = 0;
    int errors = 0;

    aes_enc_core_param #(.KEY_BITS(128), .COLS(4)) u_main (
        .clock(clock), .reset(reset),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .data_in(m_data_in), .key(m_key),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .data_out(m_data_out), .busy(m_busy)
    );

    for (genvar g = 0; g < NG; g++) begin : gen_grid
        aes_enc_core_param #(.KEY_BITS(G_KB[g]), .COLS(G_COLS[g])) u_dut (
            .clock(clock), .reset(reset),
            .in_valid(g_in_valid), .in_ready(g_in_ready[g]),
            .data_in(g_data_in), .key(g_key),
            .out_valid(g_out_valid[g]), .out_ready(g_out_ready),
            .data_out(g_data_out[g]), .busy(g_busy[g])
        );
    end

    function automatic logic [127:0] exp_ct(input int kb);
        if (kb == 128) return CT_C128;
        if (kb == 192) return CT_C192;
        return CT_C256;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(output int lat, input int bound);
        lat = 0;
        for (int n = 1; n <= bound; n++) begin
            step();
            if (m_out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic submit(input logic [127:0] pt, input logic [127:0] k);
        m_data_in  = pt;
        m_key      = {k, 128'h0};
        m_in_valid = 1'b1;
        step();
        m_in_valid = 1'b0;
    endtask

    initial begin
        int lat, n_acc, n_out, last, seen;
        int glat [NG];

        reset = 1'b1;
        m_in_valid = 1'b0; m_out_ready = 1'b0; m_data_in = '0; m_key = '0;
        g_in_valid = 1'b0; g_out_ready = 1'b0; g_data_in = '0; g_key = '0;
        step();
        step();
        check("rst_in_ready", 128'(m_in_ready), 128'd0);
        check("rst_out_valid", 128'(m_out_valid), 128'd0);
        check("rst_busy", 128'(m_busy), 128'd0);
        check("rst_data_out", m_data_out, 128'h0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(m_in_ready), 128'd1);

        // Single App. B block, latency Nr*S = 10
        submit(PT_B, KEY_B);
        check("single_busy", 128'(m_busy), 128'd1);
        check("single_in_ready", 128'(m_in_ready), 128'd0);
        wait_out(lat, 30);
        check("single_lat", 128'(lat), 128'd10);
        check("single_ct", m_data_out, CT_B);
        check("done_no_ready", 128'(m_in_ready), 128'd0);
        m_out_ready = 1'b1;
        #1;
        check("done_ready", 128'(m_in_ready), 128'd1);
        step();
        check("idle_out_valid", 128'(m_out_valid), 128'd0);
        check("idle_busy", 128'(m_busy), 128'd0);
        check("idle_data_out", m_data_out, 128'h0);

        // Eight back-to-back blocks with out_ready tied high
        m_data_in = PT_B; m_key = {KEY_B, 128'h0}; m_in_valid = 1'b1; m_out_ready = 1'b1;
        n_acc = 0; n_out = 0; last = 0;
        for (int cyc = 0; cyc < 120 && n_out < 8; cyc++) begin
            if (m_out_valid) begin
                check("b2b_ct", m_data_out, CT_B);
                if (n_out > 0) check("b2b_gap", 128'(cyc - last), 128'd11);
                last = cyc;
                n_out++;
            end
            if (m_in_valid && m_in_ready) n_acc++;
            step();
            if (n_acc == 8) m_in_valid = 1'b0;
        end
        check("b2b_count", 128'(n_out), 128'd8);
        step();
        check("b2b_idle", 128'(m_busy), 128'd0);

        // Back-pressure for 20 cycles with churning inputs
        m_out_ready = 1'b0;
        submit(PT_B, KEY_B);
        wait_out(lat, 30);
        check("bp_lat", 128'(lat), 128'd10);
        for (int i = 0; i < 20; i++) begin
            m_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m_data_in = {$urandom, $urandom, $urandom, $urandom};
            m_in_valid = i[0];
            step();
            check("bp_ct", m_data_out, CT_B);
            check("bp_out_valid", 128'(m_out_valid), 128'd1);
            check("bp_in_ready", 128'(m_in_ready), 128'd0);
        end
        m_data_in = PT_C; m_key = KEY_C; m_in_valid = 1'b1; m_out_ready = 1'b1;
        #1;
        check("bp_sim_in_ready", 128'(m_in_ready), 128'd1);
        check("bp_sim_out_valid", 128'(m_out_valid), 128'd1);
        step();
        m_in_valid = 1'b0; m_out_ready = 1'b0;
        check("bp_reload_valid", 128'(m_out_valid), 128'd0);
        check("bp_reload_busy", 128'(m_busy), 128'd1);
        wait_out(lat, 30);
        check("bp_reload_lat", 128'(lat), 128'd10);
        check("bp_reload_ct", m_data_out, CT_C128);
        m_out_ready = 1'b1;
        step();
        m_out_ready = 1'b0;
        check("bp_to_idle", 128'(m_in_ready), 128'd1);

        // Reset during round 5
        submit(PT_B, KEY_B);
        for (int i = 0; i < 4; i++) step();
        check("mid_busy", 128'(m_busy), 128'd1);
        reset = 1'b1;
        step();
        check("mid_rst_out_valid", 128'(m_out_valid), 128'd0);
        check("mid_rst_busy", 128'(m_busy), 128'd0);
        check("mid_rst_data_out", m_data_out, 128'h0);
        check("mid_rst_in_ready", 128'(m_in_ready), 128'd0);
        reset = 1'b0;
        #1;
        check("mid_post_in_ready", 128'(m_in_ready), 128'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (m_out_valid) seen = 1;
        end
        check("mid_no_out", 128'(seen), 128'd0);
        submit(PT_B, KEY_B);
        wait_out(lat, 30);
        check("mid_fresh_lat", 128'(lat), 128'd10);
        check("mid_fresh_ct", m_data_out, CT_B);
        m_out_ready = 1'b1;
        step();
        m_out_ready = 1'b0;

        // Key and plaintext change right after acceptance
        submit(PT_B, KEY_B);
        m_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        m_data_in = {$urandom, $urandom, $urandom, $urandom};
        wait_out(lat, 30);
        check("keychg_lat", 128'(lat), 128'd10);
        check("keychg_ct", m_data_out, CT_B);
        m_out_ready = 1'b1;
        step();
        m_out_ready = 1'b0;

        // Appendix C vectors across key lengths and widths
        g_data_in = PT_C; g_key = KEY_C; g_in_valid = 1'b1;
        #1;
        for (int g = 0; g < NG; g++) check($sformatf("grid_in_ready[%0d]", g), 128'(g_in_ready[g]), 128'd1);
        step();
        g_in_valid = 1'b0;
        g_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        g_data_in = {$urandom, $urandom, $urandom, $urandom};
        for (int g = 0; g < NG; g++) begin
            glat[g] = 0;
            check($sformatf("grid_busy[%0d]", g), 128'(g_busy[g]), 128'd1);
        end
        for (int n = 1; n <= 70; n++) begin
            step();
            for (int g = 0; g < NG; g++)
                if (g_out_valid[g] && glat[g] == 0) glat[g] = n;
        end
        for (int g = 0; g < NG; g++) begin
            check($sformatf("grid_lat[%0d]", g), 128'(glat[g]),
                  128'((G_KB[g] / 32 + 6) * (4 / G_COLS[g])));
            check($sformatf("grid_ct[%0d]", g), g_data_out[g], exp_ct(G_KB[g]));
        end
        g_out_ready = 1'b1;
        step();
        for (int g = 0; g < NG; g++) check($sformatf("grid_drain[%0d]", g), 128'(g_out_valid[g]), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
